unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter and sequencer for the single shared instruction/data memory used by the fetch stage. It grants the memory port either to instruction fetch (PC address) or to the MEM-stage load/store (data address), drives the address-select mux and read/write strobes, and holds each access for a fixed number of wait cycles. It generates the structural-hazard freeze for the PC/IF-ID and the stall for the MEM stage.

## Interface
- LATENCY, 3, cycles one memory access occupies the port (1..15); 1 means a single-cycle access.
- clk  in  1  pipeline clock, rising edge.
- rest  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch wants the instruction at PC; held until if_ready.
- mem_rd_req  in  1  MEM stage load request; held until data_ready.
- mem_wr_req  in  1  MEM stage store request; held until data_ready.
- mem_addr_sel  out  1  memory address mux select: 1 = data address, 0 = PC.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- if_ready  out  1  instruction word valid this cycle; PC may advance.
- data_ready  out  1  load data valid / store committed this cycle.
- freeze_pc  out  1  hold PC and IF/ID (structural hazard).
- stall_mem  out  1  hold MEM stage and all older stages' registers.
- busy  out  1  an access is in progress past its first cycle.
- stall_count  out  16  fetch-stall cycle counter (see Configuration).

## Operation
- States: IDLE, BUSY_IF, BUSY_DATA. 4-bit wait counter cnt, 1-bit last_data flag.
- IDLE grant (combinational, same cycle): data requested and not (last_data and if_req) -> data; else if_req -> fetch; else none. last_data gives fetch one access after each data access so back-to-back loads cannot starve fetch.
- Data access: mem_addr_sel=1; mem_write=1 if mem_wr_req, else mem_read=1. Both rd and wr high is illegal; write wins, mem_read stays 0.
- Fetch access: mem_addr_sel=0, mem_read=1, mem_write=0.
- LATENCY=1: access completes in grant cycle, ready pulses, state stays IDLE.
- LATENCY>1: on grant go to BUSY_IF/BUSY_DATA with cnt=LATENCY-2; decrement each cycle; ready asserted in the cycle cnt==0, then return to IDLE. Select and strobes held constant for all LATENCY cycles.
- last_data set when a data access completes, cleared when a fetch access completes.
- freeze_pc = if_req and not if_ready. stall_mem = (mem_rd_req or mem_wr_req) and not data_ready.
- Requester dropping its request mid-access: access still runs to completion; ready pulse still issued (ignored).
- No request in IDLE: all strobes 0, mem_addr_sel 0.

## Timing
- Reset values: state IDLE, cnt 0, last_data 0; mem_addr_sel, mem_read, mem_write, if_ready, data_ready, busy, stall_count all 0. freeze_pc/stall_mem follow the combinational equations, so a request pending during reset is stalled.
- Access granted at cycle t: ready high at cycle t+LATENCY-1 only (one-cycle pulse); next grant may occur at t+LATENCY (no dead cycle).
- busy high cycles t+1..t+LATENCY-1.
- Requests sampled only in IDLE; changes during BUSY do not alter the ongoing access.
- Reset asserted mid-access: access aborted immediately, no ready pulse, outputs to reset values.

## Configuration
- ARB_STALL_COUNT_EN defined: stall_count increments on each rising edge where freeze_pc=1, saturates at 16'hFFFF, cleared by rest.
- Not defined: counter logic absent; stall_count tied to 16'h0000.

## Test plan
- LATENCY=3, if_req only from reset release -> mem_read=1, mem_addr_sel=0 continuously; if_ready pulses every 3rd cycle; freeze_pc low only on pulse cycles.
- LATENCY=3, if_req and mem_rd_req together in IDLE -> data granted (mem_addr_sel=1 for 3 cycles, data_ready cycle 3), then fetch granted for 3 cycles, if_ready cycle 6.
- LATENCY=3, two consecutive loads with if_req held -> order data, fetch, data; stall_mem high 5 of 6 cycles for second load.
- LATENCY=1, mem_wr_req and mem_rd_req both high -> mem_write=1, mem_read=0, data_ready same cycle.
- LATENCY=3, rest pulsed in 2nd cycle of a store -> mem_write drops asynchronously, no data_ready, stall_count=0; store re-granted after release.
- ARB_STALL_COUNT_EN, LATENCY=4, if_req held 40 cycles -> stall_count=30.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Shared I/D memory port arbiter/sequencer with fetch/MEM stalls.
//            Optional fetch-stall counter enabled by ARB_STALL_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rest_i,
    input  logic        if_req_i,
    input  logic        mem_rd_req_i,
    input  logic        mem_wr_req_i,
    output logic        mem_addr_sel_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        if_ready_o,
    output logic        data_ready_o,
    output logic        freeze_pc_o,
    output logic        stall_mem_o,
    output logic        busy_o,
    output logic [15:0] stall_count_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_IF   = 2'd1,
        BUSY_DATA = 2'd2
    } state_t;

    localparam bit         SINGLE   = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       last_data_q;
    logic       wr_q;

    logic       grant_data;
    logic       grant_if;
    logic       data_req;

    assign data_req = mem_rd_req_i | mem_wr_req_i;

    // Grant is decided combinationally in IDLE; masked while reset is held
    // so an aborted access cannot reappear on the strobes during reset.
    assign grant_data = (state_q == IDLE) & ~rest_i & data_req
                      & ~(last_data_q & if_req_i);
    assign grant_if   = (state_q == IDLE) & ~rest_i & ~grant_data & if_req_i;

    always_comb begin
        mem_addr_sel_o = 1'b0;
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        if_ready_o     = 1'b0;
        data_ready_o   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_addr_sel_o = grant_data;
                mem_write_o    = grant_data & mem_wr_req_i;
                mem_read_o     = grant_if | (grant_data & ~mem_wr_req_i);
                if_ready_o     = SINGLE & grant_if;
                data_ready_o   = SINGLE & grant_data;
            end
            BUSY_IF: begin
                mem_read_o = 1'b1;
                if_ready_o = (cnt_q == 4'd0);
            end
            BUSY_DATA: begin
                mem_addr_sel_o = 1'b1;
                mem_write_o    = wr_q;
                mem_read_o     = ~wr_q;
                data_ready_o   = (cnt_q == 4'd0);
            end
            default: begin
                mem_addr_sel_o = 1'b0;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign freeze_pc_o = if_req_i & ~if_ready_o;
    assign stall_mem_o = data_req & ~data_ready_o;

    always_ff @(posedge clk_i or posedge rest_i) begin
        if (rest_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_data_q <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        wr_q <= mem_wr_req_i;
                        if (SINGLE) begin
                            last_data_q <= 1'b1;
                        end else begin
                            state_q <= BUSY_DATA;
                            cnt_q   <= CNT_INIT;
                        end
                    end else if (grant_if) begin
                        if (SINGLE) begin
                            last_data_q <= 1'b0;
                        end else begin
                            state_q <= BUSY_IF;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY_IF: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= IDLE;
                        last_data_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                BUSY_DATA: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= IDLE;
                        last_data_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk_i or posedge rest_i) begin
        if (rest_i) begin
            stall_count_q <= 16'h0000;
        end else if (freeze_pc_o && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'h0001;
        end
    end

    assign stall_count_o = stall_count_q;
`else
    assign stall_count_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Brief    : Directed bench for unified_mem_arbiter at LATENCY 3, 1 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Per-instance requests; observed outputs packed as
    // {sel, read, write, if_ready, data_ready, freeze_pc, stall_mem, busy}.
    logic a_if = 1'b0, a_rd = 1'b0, a_wr = 1'b0;
    logic b_if = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic c_if = 1'b0;

    logic [7:0]  a_obs, b_obs, c_obs;
    logic [15:0] a_cnt, b_cnt, c_cnt;

    unified_mem_arbiter #(.LATENCY(3)) u_dut_a (
        .clk_i(clk), .rest_i(rst),
        .if_req_i(a_if), .mem_rd_req_i(a_rd), .mem_wr_req_i(a_wr),
        .mem_addr_sel_o(a_obs[7]), .mem_read_o(a_obs[6]), .mem_write_o(a_obs[5]),
        .if_ready_o(a_obs[4]), .data_ready_o(a_obs[3]), .freeze_pc_o(a_obs[2]),
        .stall_mem_o(a_obs[1]), .busy_o(a_obs[0]), .stall_count_o(a_cnt)
    );

    unified_mem_arbiter #(.LATENCY(1)) u_dut_b (
        .clk_i(clk), .rest_i(rst),
        .if_req_i(b_if), .mem_rd_req_i(b_rd), .mem_wr_req_i(b_wr),
        .mem_addr_sel_o(b_obs[7]), .mem_read_o(b_obs[6]), .mem_write_o(b_obs[5]),
        .if_ready_o(b_obs[4]), .data_ready_o(b_obs[3]), .freeze_pc_o(b_obs[2]),
        .stall_mem_o(b_obs[1]), .busy_o(b_obs[0]), .stall_count_o(b_cnt)
    );

    unified_mem_arbiter #(.LATENCY(4)) u_dut_c (
        .clk_i(clk), .rest_i(rst),
        .if_req_i(c_if), .mem_rd_req_i(1'b0), .mem_wr_req_i(1'b0),
        .mem_addr_sel_o(c_obs[7]), .mem_read_o(c_obs[6]), .mem_write_o(c_obs[5]),
        .if_ready_o(c_obs[4]), .data_ready_o(c_obs[3]), .freeze_pc_o(c_obs[2]),
        .stall_mem_o(c_obs[1]), .busy_o(c_obs[0]), .stall_count_o(c_cnt)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // LATENCY=3 sequence: {if, rd, wr} per cycle and expected output byte.
    localparam int NA = 29;
    logic [2:0] stim_a [NA] = '{
        3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
        3'b000,
        3'b110, 3'b110, 3'b110, 3'b100, 3'b100, 3'b100,
        3'b000,
        3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110,
        3'b000,
        3'b001, 3'b001
    };
    logic [7:0] exp_a [NA] = '{
        8'h44, 8'h45, 8'h51, 8'h44, 8'h45, 8'h51, 8'h44, 8'h45, 8'h51,
        8'h00,
        8'hC6, 8'hC7, 8'hCD, 8'h44, 8'h45, 8'h51,
        8'h00,
        8'hC6, 8'hC7, 8'hCD, 8'h46, 8'h47, 8'h53, 8'hC6, 8'hC7, 8'hCD,
        8'h00,
        8'hA2, 8'hA3
    };

    // Store re-granted after the reset pulse.
    logic [2:0] stim_r [3] = '{3'b001, 3'b001, 3'b000};
    logic [7:0] exp_r  [3] = '{8'hA3, 8'hA9, 8'h00};

    // LATENCY=1 sequence.
    localparam int NB = 5;
    logic [2:0] stim_b [NB] = '{3'b011, 3'b111, 3'b110, 3'b000, 3'b100};
    logic [7:0] exp_b  [NB] = '{8'hA8, 8'h52, 8'hCC, 8'h00, 8'h50};

`ifdef ARB_STALL_COUNT_EN
    localparam logic [15:0] EXP_B_CNT = 16'd1;
    localparam logic [15:0] EXP_C_CNT = 16'd30;
`else
    localparam logic [15:0] EXP_B_CNT = 16'd0;
    localparam logic [15:0] EXP_C_CNT = 16'd0;
`endif

    initial begin
        a_if = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("a_reset_outputs", {24'd0, a_obs}, 32'h04);
        check_val("a_reset_count", {16'd0, a_cnt}, 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NA; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            {a_if, a_rd, a_wr} = stim_a[i];
            @(negedge clk);
            check_val($sformatf("a_cycle%0d", i + 1), {24'd0, a_obs}, {24'd0, exp_a[i]});
        end

        // Reset pulse in the second cycle of the store.
        #1 rst = 1'b1;
        #1;
        check_val("a_reset_mid_store", {24'd0, a_obs}, 32'h02);
        check_val("a_reset_mid_count", {16'd0, a_cnt}, 32'h0);
        #1 rst = 1'b0;
        #1;
        check_val("a_store_regrant", {24'd0, a_obs}, 32'hA2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            {a_if, a_rd, a_wr} = stim_r[i];
            @(negedge clk);
            check_val($sformatf("a_store_cycle%0d", i + 2), {24'd0, a_obs}, {24'd0, exp_r[i]});
        end

        for (int i = 0; i < NB; i++) begin
            @(posedge clk);
            #1;
            {b_if, b_rd, b_wr} = stim_b[i];
            @(negedge clk);
            check_val($sformatf("b_cycle%0d", i + 1), {24'd0, b_obs}, {24'd0, exp_b[i]});
        end
        check_val("b_stall_count", {16'd0, b_cnt}, {16'd0, EXP_B_CNT});

        @(posedge clk);
        #1;
        b_if = 1'b0;
        c_if = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 3) check_val("c_cycle3", {24'd0, c_obs}, 32'h45);
            if (i == 4) check_val("c_cycle4", {24'd0, c_obs}, 32'h51);
            @(posedge clk);
        end
        #1;
        c_if = 1'b0;
        @(negedge clk);
        check_val("c_stall_count", {16'd0, c_cnt}, {16'd0, EXP_C_CNT});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
